// File: rtl/seq_div_if.sv
// rtl/seq_div_if.sv - Start/Busy/Done handshake and operand/result bundle for seq_div
//
// Parameter n : operand/result width.
// master : drives Start, A, B; observes Quot, Rem, Busy, Done, DivZero.
// slave  : the divider side of the same signals.
interface seq_div_if #(parameter int n = 8);
    logic         Start;
    logic [n-1:0] A;
    logic [n-1:0] B;
    logic [n-1:0] Quot;
    logic [n-1:0] Rem;
    logic         Busy;
    logic         Done;
    logic         DivZero;

    modport master (
        output Start, A, B,
        input  Quot, Rem, Busy, Done, DivZero
    );

    modport slave (
        input  Start, A, B,
        output Quot, Rem, Busy, Done, DivZero
    );
endinterface

// File: rtl/seq_div.sv
// rtl/seq_div.sv - sequential restoring divider, one quotient bit per clock
//
// Parameters: n (operand width, n >= 2), SIGNED (1 = two's-complement, 0 = unsigned).
// Ports:
//   Clock  : rising-edge clock
//   nReset : asynchronous active-low reset
//   bus    : seq_div_if slave - Start/A/B in; Quot/Rem/Busy/Done/DivZero out (all registered)
module seq_div #(
    parameter int n      = 8,
    parameter bit SIGNED = 1'b1
) (
    input  logic        Clock,
    input  logic        nReset,
    seq_div_if.slave    bus
);
    localparam int CW = $clog2(n + 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t        state;
    logic [n-1:0]  dividend;    // shifts out dividend bits, shifts in quotient bits
    logic [n-1:0]  divisor;
    logic [n-1:0]  prem;        // partial remainder, always < divisor
    logic [CW-1:0] count;
    logic          neg_q;
    logic          neg_r;
    logic [n-1:0]  quot;
    logic [n-1:0]  rem;
    logic          busy;
    logic          done;
    logic          div_zero;

    // Magnitudes of the incoming operands. The most-negative pattern maps to
    // itself, which read as unsigned is exactly its magnitude.
    logic [n-1:0] a_mag;
    logic [n-1:0] b_mag;
    assign a_mag = (SIGNED && bus.A[n-1]) ? -bus.A : bus.A;
    assign b_mag = (SIGNED && bus.B[n-1]) ? -bus.B : bus.B;

    // One restoring step: shift the next dividend bit into the remainder and
    // trial-subtract. The extra top bit of diff is the borrow.
    logic [n:0]   shifted;
    logic [n+1:0] diff;
    logic         fits;
    logic [n-1:0] prem_next;
    logic [n-1:0] q_next;
    assign shifted   = {prem, dividend[n-1]};
    assign diff      = {1'b0, shifted} - {2'b00, divisor};
    assign fits      = ~diff[n+1];
    assign prem_next = fits ? diff[n-1:0] : shifted[n-1:0];
    assign q_next    = {dividend[n-2:0], fits};

    // When the subtraction fits the difference is below divisor, so bit n is zero.
    logic unused_diff_bit;
    assign unused_diff_bit = diff[n];

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state    <= IDLE;
            dividend <= '0;
            divisor  <= '0;
            prem     <= '0;
            count    <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            quot     <= '0;
            rem      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (bus.Start) begin
                        dividend <= a_mag;
                        divisor  <= b_mag;
                        prem     <= '0;
                        count    <= CW'(n);
                        neg_q    <= SIGNED && (bus.A[n-1] ^ bus.B[n-1]);
                        neg_r    <= SIGNED && bus.A[n-1];
                        div_zero <= 1'b0;
                        if (bus.B == '0) begin
                            // Divide by zero skips iteration and reports at once.
                            quot     <= '1;
                            rem      <= bus.A;
                            div_zero <= 1'b1;
                            done     <= 1'b1;
                            state    <= DONE;
                        end else begin
                            busy  <= 1'b1;
                            state <= CALC;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end

                CALC: begin
                    prem     <= prem_next;
                    dividend <= q_next;
                    count    <= count - CW'(1);
                    if (count == CW'(1)) begin
                        // Last step: publish results with the sign fix-up applied.
                        quot  <= neg_q ? -q_next : q_next;
                        rem   <= neg_r ? -prem_next : prem_next;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end

                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.Quot    = quot;
    assign bus.Rem     = rem;
    assign bus.Busy    = busy;
    assign bus.Done    = done;
    assign bus.DivZero = div_zero;
endmodule
